// File: rtl/mod_bit_counter_if.sv
// Control/status bundle for mod_bit_counter: the controller drives the
// step/load controls, the counter returns its count and status flags.
interface mod_bit_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sat_mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             load_err;

    modport master (
        output en, up_dn, clr, load, load_val, sat_mode,
        input  count, tc, wrap, ovf, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, sat_mode,
        output count, tc, wrap, ovf, load_err
    );
endinterface

// File: rtl/mod_bit_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate selection and
// terminal-count, wrap-pulse, sticky-overflow and bad-load status.
module mod_bit_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic               clk,
    input  logic               rst,
    mod_bit_counter_if.slave   bus
);
    localparam int             MAX_I = MODULUS - 1;
    // One spare bit so MODULUS = 2^WIDTH and oversized load values compare cleanly.
    localparam logic [WIDTH:0] MAX   = MAX_I[WIDTH:0];

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             ovf_q;
    logic             lerr_q;

    logic at_max;
    logic at_zero;
    logic load_ok;

    assign at_max  = ({1'b0, count_q} == MAX);
    assign at_zero = (count_q == '0);
    assign load_ok = ({1'b0, bus.load_val} <= MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
            if (bus.clr) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else if (bus.load) begin
                if (load_ok) begin
                    count_q <= bus.load_val;
                end else begin
                    count_q <= MAX[WIDTH-1:0];
                    lerr_q  <= 1'b1;
                end
            end else if (bus.en) begin
                if (bus.up_dn) begin
                    if (!at_max) begin
                        count_q <= count_q + WIDTH'(1);
                    end else begin
                        ovf_q <= 1'b1;
                        if (!bus.sat_mode) begin
                            count_q <= '0;
                            wrap_q  <= 1'b1;
                        end
                    end
                end else begin
                    if (!at_zero) begin
                        count_q <= count_q - WIDTH'(1);
                    end else begin
                        ovf_q <= 1'b1;
                        if (!bus.sat_mode) begin
                            count_q <= MAX[WIDTH-1:0];
                            wrap_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.ovf      = ovf_q;
    assign bus.load_err = lerr_q;
    // Look-ahead flag: the next enabled edge reaches a limit.
    assign bus.tc       = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
endmodule

// File: tb/tb_mod_bit_counter.sv
// Directed bench for mod_bit_counter: a 4-bit modulo-10 and an 8-bit full-range
// instance, with expected results queued at drive time and checked after each edge.
module tb_mod_bit_counter;
    logic clk;
    logic rst;

    mod_bit_counter_if #(.WIDTH(4)) b4 ();
    mod_bit_counter_if #(.WIDTH(8)) b8 ();

    mod_bit_counter #(.WIDTH(4), .MODULUS(10))  u4 (.clk(clk), .rst(rst), .bus(b4));
    mod_bit_counter #(.WIDTH(8), .MODULUS(256)) u8 (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [15:0] cnt;
        logic        wrap;
        logic        ovf;
        logic        lerr;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;
    int   stepno = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s step %0d: got %0d want %0d", tag, stepno, obs, exp);
        end
    endtask

    // Drive one instance, check tc combinationally, then check registered state after the edge.
    task automatic step(input bit d8, input logic e, input logic u, input logic c,
                        input logic l, input logic [15:0] lv, input logic s,
                        input logic tc_x, input logic [15:0] c_x,
                        input logic w_x, input logic o_x, input logic le_x);
        exp_t x;
        stepno++;
        if (!d8) begin
            b4.en = e; b4.up_dn = u; b4.clr = c; b4.load = l;
            b4.load_val = lv[3:0]; b4.sat_mode = s;
        end else begin
            b8.en = e; b8.up_dn = u; b8.clr = c; b8.load = l;
            b8.load_val = lv[7:0]; b8.sat_mode = s;
        end
        #1;
        chk("tc", d8 ? 16'(b8.tc) : 16'(b4.tc), 16'(tc_x));
        x.cnt = c_x; x.wrap = w_x; x.ovf = o_x; x.lerr = le_x;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("count",    d8 ? 16'(b8.count)    : 16'(b4.count),    x.cnt);
        chk("wrap",     d8 ? 16'(b8.wrap)     : 16'(b4.wrap),     16'(x.wrap));
        chk("ovf",      d8 ? 16'(b8.ovf)      : 16'(b4.ovf),      16'(x.ovf));
        chk("load_err", d8 ? 16'(b8.load_err) : 16'(b4.load_err), 16'(x.lerr));
    endtask

    initial begin
        rst = 1'b1;
        b4.en = 0; b4.up_dn = 0; b4.clr = 0; b4.load = 0; b4.load_val = '0; b4.sat_mode = 0;
        b8.en = 0; b8.up_dn = 0; b8.clr = 0; b8.load = 0; b8.load_val = '0; b8.sat_mode = 0;
        #3;
        chk("rst_count", 16'(b4.count), 16'd0);
        chk("rst_wrap",  16'(b4.wrap),  16'd0);
        chk("rst_ovf",   16'(b4.ovf),   16'd0);
        chk("rst_lerr",  16'(b4.load_err), 16'd0);
        chk("rst_tc",    16'(b4.tc),    16'd0);
        #4 rst = 1'b0;

        // Up-count modulo 10 from reset: 1..9,0,1,2.
        for (int i = 1; i <= 12; i++)
            step(0, 1, 1, 0, 0, 0, 0, (i == 10), 16'(i % 10), (i == 10), (i >= 10), 0);

        // Clear, then count down through the zero wrap.
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 9, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0);

        // Saturate mode: load 8, three enabled up edges, then step down.
        step(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 8, 1, 0, 8, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0, 9, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 1, 9, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 1, 1, 9, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0, 8, 0, 1, 0);

        // Out-of-range load clamps and pulses load_err; in-range load does not.
        step(0, 0, 1, 0, 1, 13, 0, 0, 9, 0, 1, 1);
        step(0, 0, 1, 0, 0, 0,  0, 0, 9, 0, 1, 0);
        step(0, 0, 1, 0, 1, 5,  0, 0, 5, 0, 1, 0);
        step(0, 0, 1, 0, 1, 10, 0, 0, 9, 0, 1, 1);

        // clr beats load and en; load beats en.
        step(0, 0, 1, 0, 1, 7, 0, 0, 7, 0, 1, 0);
        step(0, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 2, 0, 0, 2, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0, 0);

        // Asynchronous reset mid-cycle.
        rst = 1'b1;
        #1;
        chk("async_rst_count", 16'(b4.count), 16'd0);
        chk("async_rst_ovf",   16'(b4.ovf),   16'd0);
        #1 rst = 1'b0;
        b4.en = 0;

        // Full 8-bit range rollover.
        step(1, 0, 1, 0, 1, 254, 0, 0, 254, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0, 0, 255, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0,   0, 1, 0,   1, 1, 0);
        step(1, 1, 1, 0, 0, 0,   0, 0, 1,   0, 1, 0);

        chk("queue_empty", 16'(q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
